// File: rtl/menu_ctrl.sv
// menu_ctrl: debounced pushbutton menu/app screen selector
module menu_ctrl #(
  parameter int NUM_APPS  = 5,
  parameter int DB_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnC,
  input  logic       btnL,
  output logic [2:0] state,
  output logic [2:0] menu_flag,
  output logic       state_change
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [2:0] LAST = 3'(NUM_APPS);
  localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES - 1);
  logic [3:0] raw, s1, s2, db, db_q;
  logic [2:0] state_n, flag_n;
  logic pu, pd, pc, pl;
  assign raw = {btnL, btnC, btnD, btnU};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      db_q <= '0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      db_q <= db;
    end
  // level flips on the DB_CYCLES-th consecutive cycle of disagreement
  for (genvar i = 0; i < 4; i++) begin : g_db
    logic [CW-1:0] cnt;
    logic lvl;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (s2[i] == lvl) cnt <= '0;
      else if (cnt == DB_MAX) begin
        cnt <= '0;
        lvl <= ~lvl;
      end else cnt <= cnt + 1'b1;
    assign db[i] = lvl;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= 3'd0;
      menu_flag    <= 3'd1;
      state_change <= 1'b0;
    end else begin
      state        <= state_n;
      menu_flag    <= flag_n;
      state_change <= state_n != state;
    end
  always_comb begin
    state_n = state;
    flag_n  = menu_flag;
    if (state == 3'd0) begin
      if (pc) state_n = menu_flag;
      else if (pu & ~pd) flag_n = (menu_flag == 3'd1) ? LAST : menu_flag - 3'd1;
      else if (pd & ~pu) flag_n = (menu_flag == LAST) ? 3'd1 : menu_flag + 3'd1;
    end else if (pc | pl) state_n = 3'd0;
  end
  always_comb {pl, pc, pd, pu} = db & ~db_q;
endmodule

// File: tb/tb_menu_ctrl.sv
// tb_menu_ctrl: scoreboard bench for menu_ctrl with DB_CYCLES=4, NUM_APPS=5
module tb_menu_ctrl;
  localparam logic [3:0] U = 4'b0001, D = 4'b0010, C = 4'b0100, L = 4'b1000;
  typedef struct { logic [2:0] st; logic [2:0] fl; int sc; } exp_t;
  logic clk = 0, rst = 1, btnU = 0, btnD = 0, btnC = 0, btnL = 0;
  logic [2:0] state, menu_flag, s1_state, s1_flag;
  logic state_change, s1_change;
  exp_t q[$];
  exp_t e;
  int vectors = 0, errors = 0, sc_cnt = 0;
  logic [2:0] m_state = 0, m_flag = 1;
  int m_sc = 0;
  menu_ctrl #(.NUM_APPS(5), .DB_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .btnU(btnU), .btnD(btnD), .btnC(btnC), .btnL(btnL),
    .state(state), .menu_flag(menu_flag), .state_change(state_change));
  menu_ctrl #(.NUM_APPS(1), .DB_CYCLES(4)) dut1 (
    .clk(clk), .rst(rst), .btnU(btnU), .btnD(btnD), .btnC(btnC), .btnL(btnL),
    .state(s1_state), .menu_flag(s1_flag), .state_change(s1_change));
  always #5 clk = ~clk;
  always @(negedge clk) if (state_change) sc_cnt++;
  task automatic model(input logic [3:0] m);
    if (m_state == 0) begin
      if (m[2]) begin
        m_state = m_flag;
        m_sc++;
      end else if (m[0] && !m[1]) m_flag = (m_flag == 1) ? 3'd5 : m_flag - 3'd1;
      else if (m[1] && !m[0]) m_flag = (m_flag == 5) ? 3'd1 : m_flag + 3'd1;
    end else if (m[2] || m[3]) begin
      m_state = 0;
      m_sc++;
    end
    q.push_back('{m_state, m_flag, m_sc});
  endtask
  task automatic hit(input logic [3:0] m, input int hold);
    {btnL, btnC, btnD, btnU} = m;
    repeat (hold) @(negedge clk);
    {btnL, btnC, btnD, btnU} = 4'b0;
    repeat (12) @(negedge clk);
    model(m);
  endtask
  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    vectors++;
    if (state !== 3'd0 || menu_flag !== 3'd1 || state_change !== 1'b0) begin
      errors++;
      $display("FAIL reset: state=%0d flag=%0d sc=%0b, required 0/1/0", state, menu_flag, state_change);
    end
    rst = 0;
    @(negedge clk);
  endtask
  task automatic test_hold;
    hit(D, 30);
    e = q.pop_front();
    vectors++;
    if (state !== e.st || menu_flag !== e.fl || sc_cnt !== e.sc) begin
      errors++;
      $display("FAIL hold_one_press: state=%0d flag=%0d sc=%0d, required %0d/%0d/%0d", state, menu_flag, sc_cnt, e.st, e.fl, e.sc);
    end
  endtask
  task automatic test_wrap;
    logic [3:0] seq [3];
    seq = '{U, U, D};
    for (int i = 0; i < 3; i++) begin
      hit(seq[i], 10);
      e = q.pop_front();
      vectors++;
      if (state !== e.st || menu_flag !== e.fl || sc_cnt !== e.sc) begin
        errors++;
        $display("FAIL wrap[%0d]: state=%0d flag=%0d sc=%0d, required %0d/%0d/%0d", i, state, menu_flag, sc_cnt, e.st, e.fl, e.sc);
      end
    end
  endtask
  task automatic test_glitch;
    for (int i = 0; i < 5; i++) begin
      btnD = 1;
      repeat (3) @(negedge clk);
      btnD = 0;
      repeat (3) @(negedge clk);
    end
    repeat (12) @(negedge clk);
    q.push_back('{m_state, m_flag, m_sc});
    e = q.pop_front();
    vectors++;
    if (state !== e.st || menu_flag !== e.fl || sc_cnt !== e.sc) begin
      errors++;
      $display("FAIL glitch: state=%0d flag=%0d sc=%0d, required %0d/%0d/%0d", state, menu_flag, sc_cnt, e.st, e.fl, e.sc);
    end
  endtask
  task automatic test_app;
    logic [3:0] seq [5];
    seq = '{D, D, C, U, L};
    for (int i = 0; i < 5; i++) begin
      hit(seq[i], 10);
      e = q.pop_front();
      vectors++;
      if (state !== e.st || menu_flag !== e.fl || sc_cnt !== e.sc) begin
        errors++;
        $display("FAIL app[%0d]: state=%0d flag=%0d sc=%0d, required %0d/%0d/%0d", i, state, menu_flag, sc_cnt, e.st, e.fl, e.sc);
      end
    end
  endtask
  task automatic test_back_to_back;
    logic [3:0] seq [4];
    seq = '{U, C | D, C | L, U | D};
    for (int i = 0; i < 4; i++) begin
      hit(seq[i], 10);
      e = q.pop_front();
      vectors++;
      if (state !== e.st || menu_flag !== e.fl || sc_cnt !== e.sc) begin
        errors++;
        $display("FAIL combo[%0d]: state=%0d flag=%0d sc=%0d, required %0d/%0d/%0d", i, state, menu_flag, sc_cnt, e.st, e.fl, e.sc);
      end
    end
  endtask
  task automatic test_async_reset;
    logic [3:0] seq [3];
    seq = '{D, D, C};
    for (int i = 0; i < 3; i++) begin
      hit(seq[i], 10);
      e = q.pop_front();
      vectors++;
      if (state !== e.st || menu_flag !== e.fl) begin
        errors++;
        $display("FAIL to_app4[%0d]: state=%0d flag=%0d, required %0d/%0d", i, state, menu_flag, e.st, e.fl);
      end
    end
    btnU = 1;
    repeat (4) @(negedge clk);
    #2 rst = 1;
    #1;
    m_state = 0;
    m_flag = 1;
    vectors++;
    if (state !== 3'd0 || menu_flag !== 3'd1 || state_change !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: state=%0d flag=%0d sc=%0b, required 0/1/0", state, menu_flag, state_change);
    end
    @(negedge clk);
    btnU = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (20) @(negedge clk);
    q.push_back('{m_state, m_flag, m_sc});
    e = q.pop_front();
    vectors++;
    if (state !== e.st || menu_flag !== e.fl || sc_cnt !== e.sc) begin
      errors++;
      $display("FAIL post_reset: state=%0d flag=%0d sc=%0d, required %0d/%0d/%0d", state, menu_flag, sc_cnt, e.st, e.fl, e.sc);
    end
  endtask
  task automatic test_held_through_reset;
    rst = 1;
    btnD = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    m_state = 0;
    m_flag = 1;
    hit(D, 15);
    e = q.pop_front();
    vectors++;
    if (state !== e.st || menu_flag !== e.fl || sc_cnt !== e.sc) begin
      errors++;
      $display("FAIL held_reset: state=%0d flag=%0d sc=%0d, required %0d/%0d/%0d", state, menu_flag, sc_cnt, e.st, e.fl, e.sc);
    end
  endtask
  task automatic test_single_app;
    hit(L, 10);
    hit(U, 10);
    hit(D, 10);
    q.delete();
    vectors++;
    if (s1_flag !== 3'd1 || s1_state > 3'd1) begin
      errors++;
      $display("FAIL single_app: state=%0d flag=%0d, required state<=1 flag=1", s1_state, s1_flag);
    end
  endtask
  initial begin
    test_reset;
    test_hold;
    test_wrap;
    test_glitch;
    test_app;
    test_back_to_back;
    test_async_reset;
    test_held_through_reset;
    test_single_app;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
